// File: rtl/conv_result_packer_if.sv
// Handshake/config bundle for conv_result_packer: config inputs, accelerator result, AXI4-Stream out.
// slave = packer side, master = the block that drives config and results.
interface conv_result_packer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [DIM_WIDTH-1:0]  cfg_width;
  logic [DIM_WIDTH-1:0]  cfg_height;
  logic                  cfg_start;
  logic [DATA_WIDTH-1:0] cSum;
  logic                  cReady;
  logic                  m_axis_valid;
  logic [DATA_WIDTH-1:0] m_axis_data;
  logic                  m_axis_ready;
  logic                  m_axis_last;
  logic [3:0]            m_axis_keep;
  logic [LvlW-1:0]       fifo_level;
  logic                  overflow;
  logic                  frame_done;
  logic                  cfg_error;

  modport slave (
    input  cfg_width, cfg_height, cfg_start, cSum, cReady, m_axis_ready,
    output m_axis_valid, m_axis_data, m_axis_last, m_axis_keep, fifo_level, overflow,
           frame_done, cfg_error
  );

  modport master (
    output cfg_width, cfg_height, cfg_start, cSum, cReady, m_axis_ready,
    input  m_axis_valid, m_axis_data, m_axis_last, m_axis_keep, fifo_level, overflow,
           frame_done, cfg_error
  );
endinterface

// File: rtl/conv_result_packer.sv
// Captures accelerator results on cReady rising edges into a FIFO and streams them as one
// AXI4-Stream frame. Optional CONV_PACKER_RELU_EN clamps negative results to zero at the push.
module conv_result_packer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIM_WIDTH   = 16
) (
  input logic               axi_clk,
  input logic               axi_reset_n,
  conv_result_packer_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = 2 * DIM_WIDTH;
  localparam logic [DIM_WIDTH-1:0] KDim   = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [DIM_WIDTH-1:0] KDimM1 = DIM_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0]        CntOne = CW'(1);
  localparam logic [AW:0]          PtrOne = (AW + 1)'(1);
  localparam logic [AW:0]          Depth  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [CW-1:0]         r_total, r_in_cnt, r_out_cnt;
  logic                  r_crdy_q, r_crdy_qq, r_push_q;
  logic [DATA_WIDTH-1:0] r_csum_q, r_pdata_q;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic                  r_overflow, r_cfg_error;

  logic [AW:0]           w_level;
  logic                  w_empty, w_full, w_push, w_pop, w_wr_en, w_valid, w_last;
  logic                  w_dims_ok, w_start_ok, w_start_bad;
  logic [DIM_WIDTH-1:0]  w_w_out, w_h_out;
  logic [CW-1:0]         w_total;
  logic [DATA_WIDTH-1:0] w_push_data;

  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_level == '0);
  assign w_full   = (w_level == Depth);

  assign w_dims_ok   = (bus.cfg_width >= KDim) && (bus.cfg_height >= KDim);
  assign w_start_ok  = bus.cfg_start && (r_state == StIdle) && w_dims_ok;
  assign w_start_bad = bus.cfg_start && (r_state == StIdle) && !w_dims_ok;
  assign w_w_out     = bus.cfg_width - KDimM1;
  assign w_h_out     = bus.cfg_height - KDimM1;
  assign w_total     = CW'(w_w_out) * CW'(w_h_out);

  // Pushes past the frame total are ignored; drops still count so last stays aligned.
  assign w_push  = r_push_q && (r_state == StRun) && (r_in_cnt < r_total);
  assign w_valid = !w_empty && (r_state == StRun);
  assign w_pop   = w_valid && bus.m_axis_ready;
  assign w_last  = w_valid && (r_out_cnt == r_total - CntOne);
  assign w_wr_en = w_push && (!w_full || w_pop);

`ifdef CONV_PACKER_RELU_EN
  assign w_push_data = r_pdata_q[DATA_WIDTH-1] ? '0 : r_pdata_q;
`else
  assign w_push_data = r_pdata_q;
`endif

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_start_ok) w_state_d = StRun;
      StRun:   if (w_pop && w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state     <= StIdle;
      r_total     <= '0;
      r_in_cnt    <= '0;
      r_out_cnt   <= '0;
      r_crdy_q    <= 1'b0;
      r_crdy_qq   <= 1'b0;
      r_push_q    <= 1'b0;
      r_csum_q    <= '0;
      r_pdata_q   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      // Two-stage capture sets the cReady-to-valid latency at two cycles.
      r_crdy_q  <= bus.cReady;
      r_crdy_qq <= r_crdy_q;
      r_push_q  <= r_crdy_q && !r_crdy_qq;
      r_csum_q  <= bus.cSum;
      r_pdata_q <= r_csum_q;
      if (w_start_ok) begin
        r_total     <= w_total;
        r_in_cnt    <= '0;
        r_out_cnt   <= '0;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_overflow  <= 1'b0;
        r_cfg_error <= 1'b0;
      end else begin
        if (w_start_bad) r_cfg_error <= 1'b1;
        if (w_push) r_in_cnt <= r_in_cnt + CntOne;
        if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + PtrOne;
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + PtrOne;
          r_out_cnt <= r_out_cnt + CntOne;
        end
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
  end

  assign bus.m_axis_valid = w_valid;
  assign bus.m_axis_data  = w_valid ? r_mem[r_rd_ptr[AW-1:0]] : '0;
  assign bus.m_axis_last  = w_last;
  assign bus.m_axis_keep  = 4'hF;
  assign bus.fifo_level   = w_level;
  assign bus.overflow     = r_overflow;
  assign bus.frame_done   = (r_state == StDone);
  assign bus.cfg_error    = r_cfg_error;
endmodule

// File: tb/tb_conv_result_packer.sv
// Directed bench for conv_result_packer: table of frames plus hand-written corner sequences.
module tb_conv_result_packer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_result_packer_if #(.DATA_WIDTH(32), .DIM_WIDTH(16), .FIFO_DEPTH(16)) bus ();

  conv_result_packer #(
    .DATA_WIDTH(32), .KERNEL_SIZE(3), .FIFO_DEPTH(16), .DIM_WIDTH(16)
  ) dut (
    .axi_clk(clk),
    .axi_reset_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    int          rdy_mode;   // 0 always ready, 1 ready 1-of-3, 2 never ready
    int          n_pulses;
    int          exp_beats;
    logic        exp_err;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  int rdy_mode = 0;
  int unsigned cyc = 0;
  int fd_cnt = 0;
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  logic        stall_pend = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.m_axis_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rdy_mode)
        0:       bus.m_axis_ready = 1'b1;
        1:       bus.m_axis_ready = (cyc % 3 == 0);
        default: bus.m_axis_ready = 1'b0;
      endcase
    end
  end

  // Collector: beats, frame_done pulses, and AXI-S stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(bus.m_axis_valid), 64'd1);
        check("stall_data", 64'(bus.m_axis_data), 64'(stall_data));
        check("stall_last", 64'(bus.m_axis_last), 64'(stall_last));
      end
      if (bus.m_axis_valid && bus.m_axis_ready) begin
        beat_data.push_back(bus.m_axis_data);
        beat_last.push_back(bus.m_axis_last);
      end
      if (bus.frame_done) fd_cnt++;
      stall_pend = bus.m_axis_valid && !bus.m_axis_ready;
      stall_data = bus.m_axis_data;
      stall_last = bus.m_axis_last;
    end
  end

  task automatic start(input logic [15:0] w, input logic [15:0] h);
    bus.cfg_width  = w;
    bus.cfg_height = h;
    bus.cfg_start  = 1'b1;
    tick();
    bus.cfg_start  = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] d);
    bus.cReady = 1'b1;
    bus.cSum   = d;
    tick();
    bus.cReady = 1'b0;
    tick();
  endtask

  task automatic clear_log();
    beat_data.delete();
    beat_last.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic run_frame(input vec_t v, input logic [31:0] base);
    clear_log();
    rdy_mode = v.rdy_mode;
    start(v.w, v.h);
    check("cfg_error", 64'(bus.cfg_error), 64'(v.exp_err));
    for (int i = 0; i < v.n_pulses; i++) pulse(base + 32'(i));
    for (int c = 0; c < 600 && beat_data.size() < v.exp_beats; c++) tick();
    repeat (4) tick();
    check("beat_count", 64'(beat_data.size()), 64'(v.exp_beats));
    for (int i = 0; i < beat_data.size(); i++) begin
      check("beat_data", 64'(beat_data[i]), 64'(base + 32'(i)));
      check("beat_last", 64'(beat_last[i]), 64'(i == v.exp_beats - 1));
    end
    check("frame_done_cnt", 64'(fd_cnt), v.exp_err ? 64'd0 : 64'd1);
    check("valid_after", 64'(bus.m_axis_valid), 64'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic [31:0] relu_exp;
    vecs[0] = '{w: 16'd8, h: 16'd8, rdy_mode: 0, n_pulses: 36, exp_beats: 36, exp_err: 1'b0};
    vecs[1] = '{w: 16'd8, h: 16'd8, rdy_mode: 1, n_pulses: 36, exp_beats: 36, exp_err: 1'b0};
    vecs[2] = '{w: 16'd2, h: 16'd8, rdy_mode: 0, n_pulses: 2,  exp_beats: 0,  exp_err: 1'b1};
    vecs[3] = '{w: 16'd3, h: 16'd3, rdy_mode: 0, n_pulses: 1,  exp_beats: 1,  exp_err: 1'b0};
    vecs[4] = '{w: 16'd8, h: 16'd2, rdy_mode: 0, n_pulses: 2,  exp_beats: 0,  exp_err: 1'b1};
    vecs[5] = '{w: 16'd4, h: 16'd4, rdy_mode: 1, n_pulses: 4,  exp_beats: 4,  exp_err: 1'b0};
    vecs[6] = '{w: 16'd3, h: 16'd5, rdy_mode: 0, n_pulses: 3,  exp_beats: 3,  exp_err: 1'b0};

    bus.cfg_width = '0;
    bus.cfg_height = '0;
    bus.cfg_start = 1'b0;
    bus.cSum = '0;
    bus.cReady = 1'b0;
    #1;
    check("rst_valid", 64'(bus.m_axis_valid), 64'd0);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_keep", 64'(bus.m_axis_keep), 64'hF);
    check("rst_flags", 64'({bus.overflow, bus.frame_done, bus.cfg_error, bus.m_axis_last}), 64'd0);
    do_reset();

    for (int k = 0; k < 7; k++) run_frame(vecs[k], 32'h1000 * 32'(k + 1));

    // cReady-to-valid latency: rise sampled at edge N, valid only after N+2.
    do_reset();
    rdy_mode = 2;
    start(16'd4, 16'd4);
    bus.cSum = 32'h55;
    bus.cReady = 1'b1;
    tick();
    check("lat_n", 64'(bus.m_axis_valid), 64'd0);
    tick();
    check("lat_n1", 64'(bus.m_axis_valid), 64'd0);
    bus.cReady = 1'b0;
    tick();
    check("lat_n2", 64'(bus.m_axis_valid), 64'd1);
    check("lat_data", 64'(bus.m_axis_data), 64'h55);
    check("lat_level", 64'(bus.fifo_level), 64'd1);

    // Overflow: 20 results into a 16-deep FIFO with no drain.
    do_reset();
    clear_log();
    rdy_mode = 2;
    start(16'd8, 16'd8);
    for (int i = 0; i < 20; i++) pulse(32'd100 + 32'(i));
    repeat (4) tick();
    check("ovf_level", 64'(bus.fifo_level), 64'd16);
    check("ovf_flag", 64'(bus.overflow), 64'd1);
    rdy_mode = 0;
    repeat (30) tick();
    check("ovf_beats", 64'(beat_data.size()), 64'd16);
    for (int i = 0; i < beat_data.size(); i++) begin
      check("ovf_data", 64'(beat_data[i]), 64'(32'd100 + 32'(i)));
      check("ovf_last", 64'(beat_last[i]), 64'd0);
    end
    check("ovf_fd", 64'(fd_cnt), 64'd0);
    check("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Negative result: clamped under RELU, bit-exact otherwise.
    do_reset();
    clear_log();
    rdy_mode = 0;
    start(16'd4, 16'd4);
    pulse(32'hFFFF_FFF6);
    pulse(32'd5);
    repeat (6) tick();
`ifdef CONV_PACKER_RELU_EN
    relu_exp = 32'd0;
`else
    relu_exp = 32'hFFFF_FFF6;
`endif
    check("relu_beats", 64'(beat_data.size()), 64'd2);
    if (beat_data.size() == 2) begin
      check("relu_b0", 64'(beat_data[0]), 64'(relu_exp));
      check("relu_b1", 64'(beat_data[1]), 64'd5);
    end

    // Reset mid-frame: outputs drop immediately; next frame is clean.
    do_reset();
    clear_log();
    rdy_mode = 0;
    start(16'd8, 16'd8);
    for (int i = 0; i < 36 && beat_data.size() < 10; i++) pulse(32'h2000 + 32'(i));
    check("mid_beats", 64'(beat_data.size()), 64'd10);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(bus.m_axis_valid), 64'd0);
    check("mid_data", 64'(bus.m_axis_data), 64'd0);
    check("mid_level", 64'(bus.fifo_level), 64'd0);
    check("mid_flags", 64'({bus.overflow, bus.frame_done, bus.cfg_error, bus.m_axis_last}), 64'd0);
    check("mid_keep", 64'(bus.m_axis_keep), 64'hF);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    v = '{w: 16'd4, h: 16'd4, rdy_mode: 0, n_pulses: 4, exp_beats: 4, exp_err: 1'b0};
    run_frame(v, 32'h3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
